// File: rtl/uart_frame_parser_if.sv
// -----------------------------------------------------------------------------
// uart_frame_parser_if
// Purpose : groups the byte-stream handshakes and frame status of the UART
//           frame parser into one bundle.
// Signals : s_valid/s_ready/s_data            upstream byte stream
//           m_valid/m_ready/m_data/m_last     downstream payload stream
//           m_cmd/m_len                       header of the last good frame
//           frame_ok/frame_err/err_code       frame status pulses and reason
// Modports: slave  - parser side (consumes s_*, produces m_* and status)
//           master - environment side (drives s_* and m_ready)
// -----------------------------------------------------------------------------
interface uart_frame_parser_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 5
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic [7:0]            m_cmd;
   logic [LEN_W-1:0]      m_len;
   logic                  frame_ok;
   logic                  frame_err;
   logic [1:0]            err_code;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last, m_cmd, m_len,
             frame_ok, frame_err, err_code
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last, m_cmd, m_len,
             frame_ok, frame_err, err_code
   );
endinterface

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
// Purpose : hunts for SOF, parses CMD, LEN, payload and XOR checksum from the
//           UART receive byte stream, buffers the payload and streams it out
//           only once the checksum has verified. Bad frames are dropped with
//           a frame_err pulse and a sticky err_code.
// Ports   : clk  - system clock (rising edge)
//           rst  - synchronous active-high reset
//           bus  - uart_frame_parser_if.slave (byte in, payload out, status)
// Options : UFP_TIMEOUT_EN - when defined, an inter-byte timeout aborts a
//           partially received frame after TIMEOUT_CYCLES idle clocks
//           (err_code 3). When undefined the parser waits indefinitely.
// -----------------------------------------------------------------------------
module uart_frame_parser #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    MAX_LEN        = 16,
   parameter int                    LEN_W          = $clog2(MAX_LEN + 1),
   parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'hA5,
   parameter int                    TIMEOUT_CYCLES = 1250000
) (
   input logic                clk,
   input logic                rst,
   uart_frame_parser_if.slave bus
);
   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_LEN = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_LEN  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4,
      ST_EMIT = 3'd5
   } state_t;

   // Running checksum step: frame checksum is the XOR of CMD, LEN and payload.
   function automatic logic [DATA_WIDTH-1:0] xor_step(
      input logic [DATA_WIDTH-1:0] acc,
      input logic [DATA_WIDTH-1:0] b
   );
      return acc ^ b;
   endfunction

   state_t                state_r;
   logic [7:0]            cmd_r;
   logic [LEN_W-1:0]      len_r;
   logic [DATA_WIDTH-1:0] acc_r;
   logic [LEN_W-1:0]      wr_ptr_r;
   logic [LEN_W-1:0]      rd_ptr_r;   // index of the next beat to load
   logic [DATA_WIDTH-1:0] buf_r [MAX_LEN];

   logic                  s_ready_r;
   logic                  m_valid_r;
   logic [DATA_WIDTH-1:0] m_data_r;
   logic                  m_last_r;
   logic [7:0]            m_cmd_r;
   logic [LEN_W-1:0]      m_len_r;
   logic                  frame_ok_r;
   logic                  frame_err_r;
   logic [1:0]            err_code_r;

   logic                  accept_s;

   assign accept_s = bus.s_valid && s_ready_r;

`ifdef UFP_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_r;
   logic             tmo_busy_s;
   logic             tmo_hit_s;

   assign tmo_busy_s = (state_r == ST_CMD) || (state_r == ST_LEN) ||
                       (state_r == ST_PAY) || (state_r == ST_CHK);
   // The count reaches TIMEOUT_CYCLES on this edge when it sits one below it.
   assign tmo_hit_s  = tmo_busy_s && !accept_s &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter: cleared by every accepted byte, held at 0 outside a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (tmo_busy_s && !accept_s && !tmo_hit_s) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

   // Frame parser FSM with all handshake and status outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cmd_r       <= 8'h00;
         len_r       <= {LEN_W{1'b0}};
         acc_r       <= {DATA_WIDTH{1'b0}};
         wr_ptr_r    <= {LEN_W{1'b0}};
         rd_ptr_r    <= {LEN_W{1'b0}};
         s_ready_r   <= 1'b0;
         m_valid_r   <= 1'b0;
         m_data_r    <= {DATA_WIDTH{1'b0}};
         m_last_r    <= 1'b0;
         m_cmd_r     <= 8'h00;
         m_len_r     <= {LEN_W{1'b0}};
         frame_ok_r  <= 1'b0;
         frame_err_r <= 1'b0;
         err_code_r  <= 2'd0;
      end else begin
         frame_ok_r  <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Also raises s_ready on the first cycle out of reset.
               s_ready_r <= 1'b1;
               if (accept_s && (bus.s_data == SOF_BYTE)) begin
                  state_r <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (accept_s) begin
                  cmd_r   <= bus.s_data;
                  acc_r   <= bus.s_data;
                  state_r <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (accept_s) begin
                  if (bus.s_data > DATA_WIDTH'(MAX_LEN)) begin
                     frame_err_r <= 1'b1;
                     err_code_r  <= ERR_LEN;
                     state_r     <= ST_IDLE;
                  end else begin
                     len_r    <= bus.s_data[LEN_W-1:0];
                     acc_r    <= xor_step(acc_r, bus.s_data);
                     wr_ptr_r <= {LEN_W{1'b0}};
                     state_r  <= (bus.s_data == {DATA_WIDTH{1'b0}}) ? ST_CHK : ST_PAY;
                  end
               end
            end
            ST_PAY: begin
               if (accept_s) begin
                  buf_r[wr_ptr_r[ADDR_W-1:0]] <= bus.s_data;
                  acc_r    <= xor_step(acc_r, bus.s_data);
                  wr_ptr_r <= wr_ptr_r + LEN_W'(1);
                  if (wr_ptr_r == (len_r - LEN_W'(1))) begin
                     state_r <= ST_CHK;
                  end
               end
            end
            ST_CHK: begin
               if (accept_s) begin
                  if (bus.s_data != acc_r) begin
                     frame_err_r <= 1'b1;
                     err_code_r  <= ERR_CHK;
                     state_r     <= ST_IDLE;
                  end else begin
                     frame_ok_r <= 1'b1;
                     m_cmd_r    <= cmd_r;
                     m_len_r    <= len_r;
                     if (len_r != {LEN_W{1'b0}}) begin
                        state_r   <= ST_EMIT;
                        s_ready_r <= 1'b0;
                        rd_ptr_r  <= {LEN_W{1'b0}};
                     end else begin
                        state_r <= ST_IDLE;
                     end
                  end
               end
            end
            ST_EMIT: begin
               if (!m_valid_r) begin
                  // First beat is presented the cycle after frame_ok.
                  m_valid_r <= 1'b1;
                  m_data_r  <= buf_r[{ADDR_W{1'b0}}];
                  m_last_r  <= (len_r == LEN_W'(1));
                  rd_ptr_r  <= LEN_W'(1);
               end else if (bus.m_ready) begin
                  if (m_last_r) begin
                     m_valid_r <= 1'b0;
                     m_last_r  <= 1'b0;
                     s_ready_r <= 1'b1;
                     state_r   <= ST_IDLE;
                  end else begin
                     m_data_r <= buf_r[rd_ptr_r[ADDR_W-1:0]];
                     m_last_r <= (rd_ptr_r == (len_r - LEN_W'(1)));
                     rd_ptr_r <= rd_ptr_r + LEN_W'(1);
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               s_ready_r <= 1'b1;
               m_valid_r <= 1'b0;
            end
         endcase
`ifdef UFP_TIMEOUT_EN
         if (tmo_hit_s) begin
            frame_err_r <= 1'b1;
            err_code_r  <= ERR_TMO;
            state_r     <= ST_IDLE;
         end
`endif
      end
   end

   assign bus.s_ready   = s_ready_r;
   assign bus.m_valid   = m_valid_r;
   assign bus.m_data    = m_data_r;
   assign bus.m_last    = m_last_r;
   assign bus.m_cmd     = m_cmd_r;
   assign bus.m_len     = m_len_r;
   assign bus.frame_ok  = frame_ok_r;
   assign bus.frame_err = frame_err_r;
   assign bus.err_code  = err_code_r;
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Consumes the byte stream produced by the UART receive path (receiver, FIFO, read buffer) over a valid/ready handshake.
- Hunts for a start-of-frame byte and parses CMD, LEN, payload and XOR checksum.
- Buffers the payload internally and releases it downstream as a stream only after the checksum verifies.
- Malformed frames are dropped and flagged with an error pulse and code.

Parameters:
- DATA_WIDTH, 8, byte width; only 8 is supported.
- MAX_LEN, 16, maximum payload bytes per frame; also the depth of the payload buffer.
- LEN_W, $clog2(MAX_LEN+1), width of the length fields.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 1250000, inter-byte timeout in clk cycles; used only with UFP_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream byte valid.
- s_ready  output  1  parser accepts a byte this cycle.
- s_data  input  DATA_WIDTH  upstream byte.
- m_valid  output  1  payload beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  DATA_WIDTH  payload byte.
- m_last  output  1  final payload beat of the frame.
- m_cmd  output  8  CMD of the last good frame.
- m_len  output  LEN_W  LEN of the last good frame.
- frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
- frame_err  output  1  one-cycle pulse when a frame is dropped.
- err_code  output  2  reason for the drop: 1 = checksum, 2 = length, 3 = timeout; held until the next frame_err.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state = IDLE; all outputs 0; s_ready = 1 in the cycle after reset deasserts. Buffer contents are don't-care.
- Byte acceptance: a byte is accepted on a cycle where s_valid and s_ready are both 1.
- s_ready: 1 in states IDLE, CMD, LEN, PAY and CHK; 0 in EMIT. This backpressures the upstream FIFO.
- IDLE: an accepted byte equal to SOF_BYTE goes to CMD. Any other byte is discarded silently.
- CMD: latch the byte into the cmd register; checksum accumulator = byte; go to LEN.
- LEN:
  - If byte > MAX_LEN: frame_err pulses next cycle, err_code = 2, go to IDLE.
  - Otherwise latch len, accumulator ^= byte, write pointer = 0.
  - Go to CHK if len == 0, else to PAY.
- PAY: write the byte to buffer[wr_ptr]; accumulator ^= byte; wr_ptr increments. After len bytes, go to CHK.
- CHK:
  - If byte != accumulator: frame_err pulses, err_code = 1, go to IDLE.
  - Otherwise frame_ok pulses, and m_cmd/m_len update in the same cycle frame_ok is high. m_cmd/m_len then hold until the next good frame.
  - Go to EMIT if len > 0, else to IDLE.
- EMIT:
  - m_valid rises the cycle after frame_ok, with m_data = buffer[0].
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - Each handshake advances rd_ptr; sustained throughput is 1 beat per cycle.
  - m_last = 1 on beat len-1.
  - After the last handshake: m_valid = 0 next cycle, state = IDLE, s_ready = 1 again.
- Pulse timing: frame_ok and frame_err are registered and fire one cycle after the deciding byte is accepted. They never assert in the same cycle.
- SOF in mid-frame: a SOF_BYTE value inside CMD, LEN, PAY or CHK is treated as data; there is no resynchronisation.
- Reset mid-frame: any partial frame is discarded. m_valid drops the cycle after rst is sampled high.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes; SOF is excluded.

Optional Feature:
- Macro: UFP_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments in CMD, LEN, PAY and CHK.
  - On reaching TIMEOUT_CYCLES: frame_err pulses, err_code = 3, go to IDLE.
  - The counter is held at 0 in IDLE and EMIT.
- Undefined: no counter is built; the parser waits indefinitely in any state; err_code 3 is never produced.

Test Plan:
- Good frame: send A5 01 03 11 22 33 02 with m_ready = 1 -> frame_ok; m_cmd = 01; m_len = 3; beats 11, 22, 33; m_last on 33 only.
- Bad checksum: send A5 01 03 11 22 33 FF -> frame_err with err_code = 1; no m_valid; the next good frame parses correctly.
- Length overrun: send A5 01 20 -> frame_err with err_code = 2 one cycle after the LEN byte; state returns to IDLE.
- Backpressure: good 3-byte frame with m_ready toggling 1010... -> every beat held stable while stalled; s_ready = 0 throughout EMIT; no beat lost or duplicated.
- Garbage then empty frame: send 00 FF A5 07 00 07 -> leading bytes dropped; frame_ok; m_cmd = 07; m_len = 0; no m_valid.
- Timeout (macro defined, TIMEOUT_CYCLES = 100): send A5 01, then idle 100 cycles -> frame_err with err_code = 3; a subsequent good frame parses correctly.
